cpu_sram_bridge: RTL and testbench
==================================

// Module: cpu_sram_bridge
// PURPOSE
//  Sits below the CPU core and consumes its inst and data SRAM-like ports: req/wr/size/addr/wdata in; addr_ok/data_ok/rdata out.
//  Arbitrates the two ports onto one shared memory port with a valid/ready request channel and a valid-only response channel.
//  At most one transaction is outstanding at any time.
//  Byte strobes are generated from size and addr[1:0].
// PARAMETERS
//  ARB_MODE   0   0: data port has fixed priority; 1: round-robin, last granted port loses ties
//  ADDR_W     32  address width on both sides; data width is fixed at 32
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       asynchronous, active-high reset
//  inst_req       in   1       inst request valid
//  inst_wr        in   1       1 = write
//  inst_size      in   2       0 = byte, 1 = half, 2/3 = word
//  inst_addr      in   ADDR_W  byte address
//  inst_wdata     in   32      write data, lane-aligned by the CPU
//  inst_addr_ok   out  1       request accepted this cycle
//  inst_data_ok   out  1       response pulse
//  inst_rdata     out  32      read data, valid with inst_data_ok
//  data_*         -    -       identical set of 8 ports for the data side
//  mem_req        out  1       memory request valid
//  mem_wr         out  1       1 = write
//  mem_wstrb      out  4       byte enables; 4'b0000 on reads
//  mem_addr       out  ADDR_W  request address, passed unmodified
//  mem_wdata      out  32      write data
//  mem_req_ready  in   1       memory accepts request when mem_req & mem_req_ready
//  mem_resp_valid in   1       read data / write ack valid
//  mem_rdata      in   32      read data
// BEHAVIOUR
//  FSM states: IDLE, REQ, WAIT, RESP. Reset state: IDLE.
//  Reset values: all outputs 0; rdata register 0; round-robin pointer = data side.
//  IDLE:
//   - If any *_req, grant one port per ARB_MODE.
//   - Drive that port's *_addr_ok=1 combinationally in the same cycle.
//   - Latch wr/size/addr/wdata and the grant owner. Go to REQ.
//   - addr_ok is never asserted outside IDLE.
//   - Both addr_ok outputs are never high in the same cycle.
//  REQ:
//   - mem_req=1; mem_* driven from latched registers, stable until handshake.
//   - On mem_req_ready: go to WAIT.
//  WAIT:
//   - On mem_resp_valid: capture mem_rdata (captured for writes too). Go to RESP.
//   - mem_resp_valid outside WAIT is ignored.
//   - A response in the same cycle as the REQ handshake is not counted.
//  RESP:
//   - Owner's *_data_ok=1 for exactly one cycle; *_rdata = captured data.
//   - Return to IDLE. A new grant can occur next cycle.
//  Latency: addr_ok to data_ok is at least 3 cycles (zero-wait memory: REQ, WAIT, RESP).
//  Other port's data_ok stays 0; its rdata holds its last value.
//  wstrb:
//   - size 0: 4'b0001 << addr[1:0].
//   - size 1: addr[1] ? 4'b1100 : 4'b0011.
//   - size 2/3: 4'b1111.
//   - Reads: 4'b0000.
//   - Misaligned requests are not checked; strobe follows the rules above.
//  ARB_MODE 1: pointer toggles to the non-granted port on every grant.
//   - A lone requester is always granted.
//  A request held across a non-granted cycle stays pending.
//   - The CPU keeps req high; the bridge holds no queue.
//  Async reset mid-transaction: return to IDLE immediately, all outputs 0, in-flight transaction dropped.
//   - A response arriving after reset deasserts is ignored (state is IDLE).
// TESTING
//  T1 Data read:
//   - Stimulus: data_req=1, wr=0, size=2, addr=0x1000_0004; mem ready=1, resp 2 cycles later with 0xDEADBEEF.
//   - Required: data_addr_ok in cycle 0, mem_wstrb=0, one data_ok pulse with rdata=0xDEADBEEF.
//  T2 Byte write:
//   - Stimulus: data_req=1, wr=1, size=0, addr=0x...3, wdata=0xAB000000.
//   - Required: mem_wstrb=4'b1000, mem_wr=1, mem_wdata=0xAB000000; data_ok after ack.
//  T3 Contention, ARB_MODE=0:
//   - Stimulus: inst_req and data_req both held high.
//   - Required: data granted first; inst_addr_ok only on the IDLE cycle after data_data_ok.
//  T4 Round-robin, ARB_MODE=1:
//   - Stimulus: both ports request continuously for 4 transactions.
//   - Required: grants alternate D, I, D, I; no cycle has both addr_ok high.
//  T5 Backpressure:
//   - Stimulus: mem_req_ready low for 5 cycles; inst half-word read at addr[1]=1.
//   - Required: mem_addr/mem_wstrb/mem_req stable throughout; mem_wstrb=0 (read).
//  T6 Reset in WAIT:
//   - Stimulus: assert reset mid-WAIT, then deliver mem_resp_valid after release.
//   - Required: all outputs 0 asynchronously; no data_ok afterwards; next request serviced normally.

Source files
------------

// File: rtl/cpu_sram_bridge.sv
// Bridges the CPU inst/data SRAM-like ports onto one shared memory port.
// Allows one outstanding transaction; lane strobes come from size and addr[1:0].
module cpu_sram_bridge #(
   parameter int ARB_MODE = 0,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [31:0]       inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [31:0]       inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [31:0]       data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [31:0]       data_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [3:0]        mem_wstrb,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;     // 1 = data port owns the transaction
   logic              rr_q, rr_d;           // 1 = data port wins the next tie
   logic              wr_q, wr_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       inst_rdata_q, inst_rdata_d;
   logic [31:0]       data_rdata_q, data_rdata_d;

   logic              data_pref;
   logic              grant_data;
   logic              sel_wr;
   logic [1:0]        sel_size;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;

   function automatic logic [3:0] lane_strobe(input logic wr, input logic [1:0] size,
                                              input logic [1:0] lo);
      logic [3:0] s;
      if (!wr) begin
         s = 4'b0000;
      end else begin
         case (size)
            2'd0:    s = 4'b0001 << lo;
            2'd1:    s = lo[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
         endcase
      end
      return s;
   endfunction

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_d         = rr_q;
      wr_d         = wr_q;
      wstrb_d      = wstrb_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      mem_req      = 1'b0;

      data_pref  = (ARB_MODE == 0) ? 1'b1 : rr_q;
      grant_data = data_req & (data_pref | ~inst_req);
      sel_wr     = grant_data ? data_wr    : inst_wr;
      sel_size   = grant_data ? data_size  : inst_size;
      sel_addr   = grant_data ? data_addr  : inst_addr;
      sel_wdata  = grant_data ? data_wdata : inst_wdata;

      case (state_q)
         IDLE: begin
            // addr_ok is combinational, so keep it quiet while reset is held
            if ((inst_req | data_req) && !reset) begin
               data_addr_ok = grant_data;
               inst_addr_ok = ~grant_data;
               owner_d      = grant_data;
               rr_d         = ~grant_data;
               wr_d         = sel_wr;
               wstrb_d      = lane_strobe(sel_wr, sel_size, sel_addr[1:0]);
               addr_d       = sel_addr;
               wdata_d      = sel_wdata;
               state_d      = REQ;
            end
         end
         REQ: begin
            mem_req = 1'b1;
            if (mem_req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_resp_valid) begin
               if (owner_q) begin
                  data_rdata_d = mem_rdata;
               end else begin
                  inst_rdata_d = mem_rdata;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            data_data_ok = owner_q;
            inst_data_ok = ~owner_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         rr_q         <= 1'b1;
         wr_q         <= 1'b0;
         wstrb_q      <= 4'b0000;
         addr_q       <= '0;
         wdata_q      <= 32'h0;
         inst_rdata_q <= 32'h0;
         data_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_q         <= rr_d;
         wr_q         <= wr_d;
         wstrb_q      <= wstrb_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   assign mem_wr     = wr_q;
   assign mem_wstrb  = wstrb_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign inst_rdata = inst_rdata_q;
   assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Directed bench: dut_a uses fixed data priority, dut_b round-robin; both share
// every input so single-port scenarios behave identically on the two copies.
module tb_cpu_sram_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inst_req = 1'b0, inst_wr = 1'b0;
   logic [1:0]  inst_size = 2'd0;
   logic [31:0] inst_addr = 32'h0, inst_wdata = 32'h0;
   logic        data_req = 1'b0, data_wr = 1'b0;
   logic [1:0]  data_size = 2'd0;
   logic [31:0] data_addr = 32'h0, data_wdata = 32'h0;
   logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   logic        a_inst_addr_ok, a_inst_data_ok, a_data_addr_ok, a_data_data_ok;
   logic [31:0] a_inst_rdata, a_data_rdata;
   logic        a_mem_req, a_mem_wr;
   logic [3:0]  a_mem_wstrb;
   logic [31:0] a_mem_addr, a_mem_wdata;
   logic        b_inst_addr_ok, b_inst_data_ok, b_data_addr_ok, b_data_data_ok;
   logic [31:0] b_inst_rdata, b_data_rdata;
   logic        b_mem_req, b_mem_wr;
   logic [3:0]  b_mem_wstrb;
   logic [31:0] b_mem_addr, b_mem_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Automatic memory: accepts immediately, responds one cycle after the handshake.
   logic        auto_mem = 1'b0;
   logic        pend = 1'b0;
   logic [31:0] auto_cnt = 32'h0;

   always #5 clk = ~clk;

   cpu_sram_bridge #(.ARB_MODE(0), .ADDR_W(32)) dut_a (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_addr_ok(a_inst_addr_ok), .inst_data_ok(a_inst_data_ok),
      .inst_rdata(a_inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(a_data_addr_ok), .data_data_ok(a_data_data_ok),
      .data_rdata(a_data_rdata),
      .mem_req(a_mem_req), .mem_wr(a_mem_wr), .mem_wstrb(a_mem_wstrb), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
      .mem_rdata(mem_rdata)
   );

   cpu_sram_bridge #(.ARB_MODE(1), .ADDR_W(32)) dut_b (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_addr_ok(b_inst_addr_ok), .inst_data_ok(b_inst_data_ok),
      .inst_rdata(b_inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(b_data_addr_ok), .data_data_ok(b_data_data_ok),
      .data_rdata(b_data_rdata),
      .mem_req(b_mem_req), .mem_wr(b_mem_wr), .mem_wstrb(b_mem_wstrb), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
      .mem_rdata(mem_rdata)
   );

   always @(negedge clk) begin
      if (auto_mem) begin
         mem_resp_valid = 1'b0;
         if (pend) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'hA5A5_0000 + auto_cnt;
            auto_cnt       = auto_cnt + 32'd1;
            pend           = 1'b0;
         end else if (a_mem_req && mem_req_ready) begin
            pend = 1'b1;
         end
      end
   end

   task automatic test_reset();
      inst_req = 1'b1;
      #3;
      n_checks++;
      if ({a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok, a_mem_req, a_mem_wr} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok, a_mem_req, a_mem_wr});
      end
      n_checks++;
      if ({a_mem_wstrb, a_mem_addr, a_mem_wdata, a_inst_rdata, a_data_rdata} !== 132'h0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h rdata=%h/%h expected zeros",
                  a_mem_addr, a_inst_rdata, a_data_rdata);
      end
      n_checks++;
      if (b_inst_addr_ok !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_b_addr_ok: got %b expected 0", b_inst_addr_ok);
      end
      inst_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      $display("txn reset released");
   endtask

   task automatic test_data_read();
      mem_req_ready = 1'b1;
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1000_0004;
      #1;
      n_checks++;
      if ({a_data_addr_ok, a_inst_addr_ok} !== 2'b10) begin
         n_fail++;
         $display("FAIL t1_addr_ok: got d=%b i=%b expected d=1 i=0", a_data_addr_ok, a_inst_addr_ok);
      end
      @(negedge clk);
      data_req = 1'b0;
      #1;
      n_checks++;
      if ({a_mem_req, a_mem_wr, a_mem_wstrb} !== 6'b10_0000 || a_mem_addr !== 32'h1000_0004) begin
         n_fail++;
         $display("FAIL t1_mem_req: got req=%b wr=%b strb=%b addr=%h expected 1 0 0000 10000004",
                  a_mem_req, a_mem_wr, a_mem_wstrb, a_mem_addr);
      end
      n_checks++;
      if (a_data_addr_ok !== 1'b0) begin
         n_fail++;
         $display("FAIL t1_addr_ok_outside_idle: got %b expected 0", a_data_addr_ok);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({a_mem_req, a_data_data_ok} !== 2'b00) begin
         n_fail++;
         $display("FAIL t1_wait: got req=%b data_ok=%b expected 0 0", a_mem_req, a_data_data_ok);
      end
      @(negedge clk);
      mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      n_checks++;
      if ({a_data_data_ok, a_inst_data_ok} !== 2'b10 || a_data_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL t1_resp: got d_ok=%b i_ok=%b rdata=%h expected 1 0 deadbeef",
                  a_data_data_ok, a_inst_data_ok, a_data_rdata);
      end
      n_checks++;
      if (b_data_data_ok !== 1'b1 || b_data_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL t1_resp_b: got ok=%b rdata=%h expected 1 deadbeef", b_data_data_ok, b_data_rdata);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (a_data_data_ok !== 1'b0) begin
         n_fail++;
         $display("FAIL t1_single_pulse: got %b expected 0", a_data_data_ok);
      end
      $display("txn T1 data read addr=10000004");
   endtask

   task automatic test_byte_write_strobes();
      logic [1:0]  sz [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
      logic [1:0]  lo [8] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0};
      logic [3:0]  ex [8] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0011, 4'b1100, 4'b1111, 4'b1111};
      logic [31:0] wd [8] = '{32'hAB00_0000, 32'h0000_0011, 32'h0000_2200, 32'h0033_0000,
                              32'h0000_4455, 32'h6677_0000, 32'h8899_AABB, 32'hCCDD_EEFF};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         data_req = 1'b1; data_wr = 1'b1; data_size = sz[i];
         data_addr = {30'h0400_0000, lo[i]}; data_wdata = wd[i];
         #1;
         n_checks++;
         if (a_data_addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL t2_addr_ok[%0d]: got %b expected 1", i, a_data_addr_ok);
         end
         @(negedge clk);
         data_req = 1'b0;
         #1;
         n_checks++;
         if (a_mem_wstrb !== ex[i] || a_mem_wr !== 1'b1 || a_mem_wdata !== wd[i] || a_mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL t2_strobe[%0d]: got strb=%b wr=%b wdata=%h req=%b expected %b 1 %h 1",
                     i, a_mem_wstrb, a_mem_wr, a_mem_wdata, a_mem_req, ex[i], wd[i]);
         end
         @(negedge clk);
         mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_F000 + 32'(i);
         @(negedge clk);
         mem_resp_valid = 1'b0;
         #1;
         n_checks++;
         if (a_data_data_ok !== 1'b1 || a_data_rdata !== 32'h0BAD_F000 + 32'(i)) begin
            n_fail++;
            $display("FAIL t2_ack[%0d]: got ok=%b rdata=%h expected 1 %h",
                     i, a_data_data_ok, a_data_rdata, 32'h0BAD_F000 + 32'(i));
         end
         $display("txn T2 write size=%0d lo=%0d strb=%b", sz[i], lo[i], a_mem_wstrb);
      end
      data_wr = 1'b0;
   endtask

   task automatic test_contention_fixed();
      auto_mem = 1'b1;
      @(negedge clk);
      data_req = 1'b1; data_addr = 32'h0000_0100; data_size = 2'd2;
      inst_req = 1'b1; inst_addr = 32'h0000_0200; inst_size = 2'd2; inst_wr = 1'b0;
      #1;
      n_checks++;
      if ({a_data_addr_ok, a_inst_addr_ok} !== 2'b10) begin
         n_fail++;
         $display("FAIL t3_first_grant: got d=%b i=%b expected d=1 i=0", a_data_addr_ok, a_inst_addr_ok);
      end
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) data_req = 1'b0;
         if (c == 5) inst_req = 1'b0;
         #1;
         if (c == 3) begin
            n_checks++;
            if ({a_data_data_ok, a_inst_addr_ok} !== 2'b10 || a_data_rdata !== 32'hA5A5_0000) begin
               n_fail++;
               $display("FAIL t3_data_done: got ok=%b i_addr_ok=%b rdata=%h expected 1 0 a5a50000",
                        a_data_data_ok, a_inst_addr_ok, a_data_rdata);
            end
         end else if (c == 4) begin
            n_checks++;
            if ({a_inst_addr_ok, a_data_addr_ok} !== 2'b10) begin
               n_fail++;
               $display("FAIL t3_inst_grant: got i=%b d=%b expected i=1 d=0", a_inst_addr_ok, a_data_addr_ok);
            end
         end else if (c == 7) begin
            n_checks++;
            if ({a_inst_data_ok, a_data_data_ok} !== 2'b10 || a_inst_rdata !== 32'hA5A5_0001) begin
               n_fail++;
               $display("FAIL t3_inst_done: got i_ok=%b d_ok=%b rdata=%h expected 1 0 a5a50001",
                        a_inst_data_ok, a_data_data_ok, a_inst_rdata);
            end
         end else begin
            n_checks++;
            if (a_inst_addr_ok !== 1'b0) begin
               n_fail++;
               $display("FAIL t3_inst_early[%0d]: got %b expected 0", c, a_inst_addr_ok);
            end
         end
      end
      $display("txn T3 contention data then inst");
   endtask

   task automatic test_round_robin();
      logic [3:0] b_seq = 4'b0;   // 1 = data grant
      logic [3:0] a_seq = 4'b0;
      int         nb = 0;
      int         na = 0;
      logic       both_seen = 1'b0;
      logic       drop = 1'b0;
      data_req = 1'b1; data_addr = 32'h0000_0400;
      inst_req = 1'b1; inst_addr = 32'h0000_0500;
      for (int c = 0; c < 20; c++) begin
         #1;
         if ((b_inst_addr_ok && b_data_addr_ok) || (a_inst_addr_ok && a_data_addr_ok)) both_seen = 1'b1;
         if ((b_inst_addr_ok || b_data_addr_ok) && nb < 4) begin
            b_seq[nb] = b_data_addr_ok;
            nb++;
            if (nb == 4) drop = 1'b1;
         end
         if ((a_inst_addr_ok || a_data_addr_ok) && na < 4) begin
            a_seq[na] = a_data_addr_ok;
            na++;
         end
         @(negedge clk);
         if (drop) begin
            data_req = 1'b0; inst_req = 1'b0;
         end
      end
      auto_mem = 1'b0;
      mem_resp_valid = 1'b0;
      #1;
      n_checks++;
      if (both_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL t4_both_addr_ok: got %b expected 0", both_seen);
      end
      n_checks++;
      if (nb != 4 || b_seq !== 4'b0101) begin
         n_fail++;
         $display("FAIL t4_rr_order: got n=%0d seq=%b expected n=4 seq=0101 (D,I,D,I)", nb, b_seq);
      end
      n_checks++;
      if (na != 4 || a_seq !== 4'b1111) begin
         n_fail++;
         $display("FAIL t4_fixed_order: got n=%0d seq=%b expected n=4 seq=1111", na, a_seq);
      end
      n_checks++;
      if (b_data_rdata !== 32'hA5A5_0004 || b_inst_rdata !== 32'hA5A5_0005) begin
         n_fail++;
         $display("FAIL t4_rr_rdata: got d=%h i=%h expected a5a50004 a5a50005", b_data_rdata, b_inst_rdata);
      end
      n_checks++;
      if (a_data_rdata !== 32'hA5A5_0005 || a_inst_rdata !== 32'hA5A5_0001) begin
         n_fail++;
         $display("FAIL t4_fixed_rdata: got d=%h i=%h expected a5a50005 a5a50001", a_data_rdata, a_inst_rdata);
      end
      $display("txn T4 round-robin grants seq=%b", b_seq);
   endtask

   task automatic test_backpressure();
      mem_req_ready = 1'b0;
      @(negedge clk);
      inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd1; inst_addr = 32'h2000_0002;
      #1;
      n_checks++;
      if ({a_inst_addr_ok, a_data_addr_ok} !== 2'b10) begin
         n_fail++;
         $display("FAIL t5_grant: got i=%b d=%b expected 1 0", a_inst_addr_ok, a_data_addr_ok);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         inst_req = 1'b0;
         #1;
         n_checks++;
         if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h2000_0002 || a_mem_wstrb !== 4'b0000 || a_mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_stall[%0d]: got req=%b addr=%h strb=%b wr=%b expected 1 20000002 0000 0",
                     k, a_mem_req, a_mem_addr, a_mem_wstrb, a_mem_wr);
         end
      end
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      n_checks++;
      if ({a_inst_data_ok, a_data_data_ok} !== 2'b10 || a_inst_rdata !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL t5_resp: got i_ok=%b d_ok=%b rdata=%h expected 1 0 12345678",
                  a_inst_data_ok, a_data_data_ok, a_inst_rdata);
      end
      n_checks++;
      if (b_data_rdata !== 32'hA5A5_0004) begin
         n_fail++;
         $display("FAIL t5_other_hold: got %h expected a5a50004", b_data_rdata);
      end
      $display("txn T5 half read under backpressure addr=20000002");
   endtask

   task automatic test_reset_in_wait();
      mem_req_ready = 1'b1;
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1000_0010;
      @(negedge clk);
      data_req = 1'b0;
      @(negedge clk);
      mem_req_ready = 1'b0;
      data_req = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok, a_mem_req, a_mem_wr} !== 6'b0) begin
         n_fail++;
         $display("FAIL t6_async_ctrl: got %b expected 000000",
                  {a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok, a_mem_req, a_mem_wr});
      end
      n_checks++;
      if (a_mem_addr !== 32'h0 || a_mem_wstrb !== 4'h0 || a_inst_rdata !== 32'h0 || a_data_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL t6_async_data: got addr=%h strb=%b i_rd=%h d_rd=%h expected zeros",
                  a_mem_addr, a_mem_wstrb, a_inst_rdata, a_data_rdata);
      end
      @(negedge clk);
      reset = 1'b0; data_req = 1'b0;
      @(negedge clk);
      mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if ({a_data_data_ok, a_inst_data_ok, b_data_data_ok} !== 3'b000 || a_data_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL t6_stale_resp[%0d]: got ok=%b rdata=%h expected 000 00000000",
                     k, {a_data_data_ok, a_inst_data_ok, b_data_data_ok}, a_data_rdata);
         end
         @(negedge clk);
      end
      inst_req = 1'b1; inst_wr = 1'b1; inst_size = 2'd2; inst_addr = 32'h3000_0008; inst_wdata = 32'h1122_3344;
      #1;
      n_checks++;
      if (a_inst_addr_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL t6_regrant: got %b expected 1", a_inst_addr_ok);
      end
      @(negedge clk);
      inst_req = 1'b0; mem_req_ready = 1'b1;
      #1;
      n_checks++;
      if (a_mem_wstrb !== 4'b1111 || a_mem_wr !== 1'b1 || a_mem_wdata !== 32'h1122_3344 || a_mem_addr !== 32'h3000_0008) begin
         n_fail++;
         $display("FAIL t6_word_write: got strb=%b wr=%b wdata=%h addr=%h expected 1111 1 11223344 30000008",
                  a_mem_wstrb, a_mem_wr, a_mem_wdata, a_mem_addr);
      end
      @(negedge clk);
      mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0ACE;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      n_checks++;
      if (a_inst_data_ok !== 1'b1 || a_inst_rdata !== 32'h0000_0ACE) begin
         n_fail++;
         $display("FAIL t6_after_reset_resp: got ok=%b rdata=%h expected 1 00000ace", a_inst_data_ok, a_inst_rdata);
      end
      $display("txn T6 reset in WAIT then word write addr=30000008");
   endtask

   initial begin
      test_reset();
      test_data_read();
      test_byte_write_strobes();
      test_contention_fixed();
      test_round_robin();
      test_backpressure();
      test_reset_in_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
